// File: rtl/perc_sched_pkg.sv
// Shared widths, constants, state encoding and arithmetic helpers for the
// percentage scheduler.
package perc_sched_pkg;

  localparam int N_CH_DEF = 4;
  localparam int OP_W     = 16;
  localparam int DVD_W    = 23;
  localparam int PCT_W    = 8;
  localparam int ITER     = 23;
  localparam int SAT      = 255;
  localparam int CNT_W    = 5;
  localparam int CH_W     = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  // Rounded dividend: num*100 + floor(den/2); the worst case still fits in 23 bits.
  function automatic logic [DVD_W-1:0] make_dividend(input logic [OP_W-1:0] num,
                                                     input logic [OP_W-1:0] den);
    return DVD_W'(num) * DVD_W'(100) + DVD_W'(den >> 1);
  endfunction

  function automatic logic [PCT_W-1:0] sat_pct(input logic [DVD_W-1:0] q);
    if (q > DVD_W'(SAT)) return PCT_W'(SAT);
    return q[PCT_W-1:0];
  endfunction

endpackage

// File: rtl/perc_div.sv
// Restoring divider, one quotient bit per clock, ITER iterations per start.
// done pulses for one cycle on the edge after the last iteration completes.
module perc_div
  import perc_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [OP_W-1:0]  divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  logic [DVD_W-1:0] dvd_q;
  logic [DVD_W-1:0] quo_q;
  logic [OP_W-1:0]  dsr_q;
  logic [OP_W-1:0]  rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  logic [OP_W:0]    trial;
  logic             fits;

  always_comb begin
    trial = {rem_q, dvd_q[DVD_W-1]};
    fits  = (trial >= {1'b0, dsr_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        dvd_q <= dividend;
        dsr_q <= divisor;
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= CNT_W'(ITER);
        run_q <= 1'b1;
      end else if (run_q) begin
        // Remainder stays below the divisor, so 16 bits always suffice.
        if (fits) rem_q <= OP_W'(trial - {1'b0, dsr_q});
        else      rem_q <= trial[OP_W-1:0];
        quo_q <= {quo_q[DVD_W-2:0], fits};
        dvd_q <= dvd_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/perc_sched.sv
// Round-robin scheduler that grants one channel at a time and computes its
// rounded, saturated percentage num/den with a shared iterative divider.
//
// state   | meaning
// IDLE    | arbitrating; zero-denominator jobs complete here via zero_pend_q
// CALC    | divider running, result registered on divider done
module perc_sched
  import perc_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_CH-1:0]      req,
  input  logic [OP_W*N_CH-1:0] numerator,
  input  logic [OP_W*N_CH-1:0] denominator,
  output logic [N_CH-1:0]      ack,
  output logic                 busy,
  output logic                 result_valid,
  output logic [PCT_W-1:0]     percent,
  output logic [CH_W-1:0]      result_ch,
  output logic                 div0
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  rr_ptr_q;
  logic [CH_W-1:0]  cur_ch_q;
  logic             zero_pend_q;

  logic [7:0]       req_pad;
  logic [CH_W:0]    idx;
  logic [CH_W-1:0]  gnt_idx;
  logic             found;
  logic [OP_W-1:0]  num_sel;
  logic [OP_W-1:0]  den_sel;
  logic [N_CH-1:0]  gnt_onehot;
  logic [CH_W-1:0]  rr_next;
  logic             grant_ok;
  logic             div_start;
  logic             div_done;
  logic [DVD_W-1:0] quotient;

  // First set request at or after rr_ptr, wrapping; an X bit never wins.
  always_comb begin
    req_pad = 8'(req);
    idx     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
      if (!found && req_pad[idx[CH_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    num_sel = '0;
    den_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        num_sel = numerator[OP_W*i +: OP_W];
        den_sel = denominator[OP_W*i +: OP_W];
      end
    end
  end

  always_comb begin
    grant_ok   = (state_q == ST_IDLE) && !zero_pend_q && enable && found;
    div_start  = grant_ok && (den_sel != '0);
    gnt_onehot = N_CH'(1) << gnt_idx;
    rr_next    = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (div_start) state_d = ST_CALC;
      ST_CALC: if (div_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      cur_ch_q     <= '0;
      zero_pend_q  <= 1'b0;
      ack          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      percent      <= '0;
      result_ch    <= '0;
      div0         <= 1'b0;
    end else begin
      ack          <= '0;
      result_valid <= 1'b0;
      zero_pend_q  <= 1'b0;
      if (result_valid) busy <= 1'b0;

      if (grant_ok) begin
        ack         <= gnt_onehot;
        busy        <= 1'b1;
        cur_ch_q    <= gnt_idx;
        zero_pend_q <= (den_sel == '0);
      end

      if (zero_pend_q) begin
        result_valid <= 1'b1;
        percent      <= PCT_W'(SAT);
        div0         <= 1'b1;
        result_ch    <= cur_ch_q;
        rr_ptr_q     <= rr_next;
      end else if ((state_q == ST_CALC) && div_done) begin
        result_valid <= 1'b1;
        percent      <= sat_pct(quotient);
        div0         <= 1'b0;
        result_ch    <= cur_ch_q;
        rr_ptr_q     <= rr_next;
      end
    end
  end

  perc_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (make_dividend(num_sel, den_sel)),
    .divisor  (den_sel),
    .done     (div_done),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_perc_sched.sv
// Directed bench for perc_sched: vector table of single jobs plus sequences
// for fairness, reset during a calculation and enable gating.
module tb_perc_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [63:0] numerator;
  logic [63:0] denominator;
  logic [3:0]  ack;
  logic        busy;
  logic        result_valid;
  logic [7:0]  percent;
  logic [2:0]  result_ch;
  logic        div0;

  int checks = 0;
  int errors = 0;

  perc_sched #(.N_CH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .req          (req),
    .numerator    (numerator),
    .denominator  (denominator),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .percent      (percent),
    .result_ch    (result_ch),
    .div0         (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] num;
    logic [15:0] den;
    logic [7:0]  pct;
    logic        dz;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One job on an otherwise idle scheduler: grant next edge, then result.
  task automatic run_job(input int ch, input logic [15:0] num, input logic [15:0] den,
                         input logic [7:0] pct, input logic dz);
    int   t;
    int   k;
    logic extra;
    @(negedge clk);
    numerator[16*ch +: 16]   = num;
    denominator[16*ch +: 16] = den;
    req[ch] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (ack == '0 && t < 40);
    check("grant_wait", t, 1);
    check("ack_onehot", 32'(ack), 32'(4'b0001 << ch));
    check("rv_at_grant", 32'(result_valid), 0);
    req[ch] = 1'b0;
    numerator[16*ch +: 16]   = num ^ 16'hA5A5;
    denominator[16*ch +: 16] = den ^ 16'h0F0F;
    k = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (ack != '0) extra = 1'b1;
    end while (!result_valid && k < 60);
    check("latency", k, dz ? 1 : 24);
    check("percent", 32'(percent), 32'(pct));
    check("result_ch", 32'(result_ch), ch);
    check("div0", 32'(div0), 32'(dz));
    check("busy_at_result", 32'(busy), 1);
    check("ack_single_pulse", 32'(extra), 0);
    @(negedge clk);
    check("rv_one_cycle", 32'(result_valid), 0);
    check("busy_after", 32'(busy), 0);
    check("percent_held", 32'(percent), 32'(pct));
  endtask

  initial begin
    int   ng;
    int   nres;
    int   gseq[5];
    int   rseq[5];
    int   exp_order[5];
    int   t;
    logic seen;

    vecs[0]  = '{1, 16'd1,     16'd3,     8'd33,  1'b0};
    vecs[1]  = '{0, 16'd2,     16'd3,     8'd67,  1'b0};
    vecs[2]  = '{2, 16'd50,    16'd100,   8'd50,  1'b0};
    vecs[3]  = '{3, 16'd300,   16'd100,   8'd255, 1'b0};
    vecs[4]  = '{1, 16'd65535, 16'd1,     8'd255, 1'b0};
    vecs[5]  = '{2, 16'd7,     16'd0,     8'd255, 1'b1};
    vecs[6]  = '{0, 16'd0,     16'd5,     8'd0,   1'b0};
    vecs[7]  = '{3, 16'd1,     16'd200,   8'd1,   1'b0};
    vecs[8]  = '{3, 16'd1,     16'd201,   8'd0,   1'b0};
    vecs[9]  = '{1, 16'd255,   16'd100,   8'd255, 1'b0};
    vecs[10] = '{2, 16'd256,   16'd100,   8'd255, 1'b0};
    vecs[11] = '{0, 16'd99,    16'd99,    8'd100, 1'b0};
    vecs[12] = '{3, 16'd65535, 16'd65535, 8'd100, 1'b0};
    vecs[13] = '{0, 16'd12345, 16'd65535, 8'd19,  1'b0};
    vecs[14] = '{2, 16'd0,     16'd0,     8'd255, 1'b1};
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    enable = 1'b1;
    req = '0;
    numerator = '0;
    denominator = '0;
    do_reset();
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_percent", 32'(percent), 0);
    check("rst_result_ch", 32'(result_ch), 0);
    check("rst_div0", 32'(div0), 0);

    for (int i = 0; i < 15; i++)
      run_job(vecs[i].ch, vecs[i].num, vecs[i].den, vecs[i].pct, vecs[i].dz);

    // Fairness: every channel requesting from reset onward.
    @(negedge clk);
    reset = 1'b1;
    req = 4'hF;
    for (int c = 0; c < 4; c++) begin
      numerator[16*c +: 16]   = 16'd1;
      denominator[16*c +: 16] = 16'd2;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ng = 0;
    nres = 0;
    t = 0;
    while (!(ng == 5 && nres == 5) && t < 300) begin
      @(negedge clk);
      t++;
      if (ack != '0) begin
        for (int c = 0; c < 4; c++) if (ack[c]) gseq[ng] = c;
        check("fair_result_before_grant", nres, ng);
        ng++;
        if (ng == 5) req = '0;
      end
      if (result_valid) begin
        if (nres < 5) rseq[nres] = 32'(result_ch);
        check("fair_percent", 32'(percent), 50);
        nres++;
      end
    end
    check("fair_grants", ng, 5);
    check("fair_results", nres, 5);
    for (int i = 0; i < 5; i++) begin
      check("fair_order", gseq[i], exp_order[i]);
      check("fair_result_ch", rseq[i], exp_order[i]);
    end

    // Reset during CALC: rr_ptr is 2 after the ch1 job, then must return to 0.
    run_job(1, 16'd10, 16'd20, 8'd50, 1'b0);
    @(negedge clk);
    numerator[48 +: 16] = 16'd5;
    denominator[48 +: 16] = 16'd7;
    req[3] = 1'b1;
    @(negedge clk);
    check("mid_ack3", 32'(ack), 8);
    req[3] = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy_cleared", 32'(busy), 0);
    check("mid_percent_cleared", 32'(percent), 0);
    check("mid_result_ch_cleared", 32'(result_ch), 0);
    repeat (40) begin
      @(negedge clk);
      if (result_valid || ack != '0) seen = 1'b1;
    end
    check("mid_no_result", 32'(seen), 0);
    numerator[0 +: 16] = 16'd3;
    denominator[0 +: 16] = 16'd4;
    req = 4'b1001;
    @(negedge clk);
    check("mid_next_grant_ch0", 32'(ack), 1);
    req = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (!result_valid && t < 60);
    check("mid_next_latency", t, 24);
    check("mid_next_percent", 32'(percent), 75);
    check("mid_next_result_ch", 32'(result_ch), 0);

    // Enable gating: no grant while low; in-flight job completes with enable low.
    @(negedge clk);
    enable = 1'b0;
    numerator[0 +: 16] = 16'd1;
    denominator[0 +: 16] = 16'd1;
    req[0] = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0 || busy) seen = 1'b1;
    end
    check("en_low_no_ack", 32'(seen), 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_ack0", 32'(ack), 1);
    req[0] = 1'b0;
    enable = 1'b0;
    req[2] = 1'b1;
    t = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      t++;
      if (ack != '0) seen = 1'b1;
    end while (!result_valid && t < 60);
    check("en_low_latency", t, 24);
    check("en_low_percent", 32'(percent), 100);
    repeat (5) begin
      @(negedge clk);
      if (ack != '0) seen = 1'b1;
    end
    check("en_low_hold_grants", 32'(seen), 0);
    req = '0;
    enable = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perc_sched.md
PERC_SCHED -- requirements
Module: perc_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1; when low, no new grants are issued.
REQ-005 SHALL have port req, input, N_CH, per-channel request level, held until ack.
REQ-006 SHALL have port numerator, input, 16*N_CH, packed per-channel numerators; channel i at bits [16i+15:16i].
REQ-007 SHALL have port denominator, input, 16*N_CH, packed per-channel denominators, same packing as numerator.
REQ-008 SHALL have port ack, output, N_CH, one-cycle grant pulse to the serviced channel.
REQ-009 SHALL have port busy, output, 1, high from grant until result_valid inclusive.
REQ-010 SHALL have port result_valid, output, 1, one-cycle result strobe.
REQ-011 SHALL have port percent, output, 8, result value, held until next result_valid.
REQ-012 SHALL have port result_ch, output, 3, channel index of percent.
REQ-013 SHALL have port div0, output, 1, high with result_valid when the denominator was zero.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> IDLE, with IDLE -> IDLE for zero-denominator grants.
REQ-015 SHALL, in IDLE with enable=1 and any req bit set at edge E0, grant the first set bit at or after rr_ptr (wrapping N_CH-1 -> 0).
REQ-016 SHALL, at E0, latch the granted numerator and denominator and drive ack[g]=1 for exactly the cycle following E0.
REQ-017 SHALL sample operands only at grant; operand changes after E0 have no effect.
REQ-018 SHALL compute percent = min(255, floor((num*100 + floor(den/2)) / den)) using a 23-bit dividend and a 16-bit divisor.
REQ-019 SHALL perform restoring division, one quotient bit per cycle, 23 iterations in CALC.
REQ-020 SHALL, for den != 0, register result_valid=1 at E24 with fixed latency, independent of operand values.
REQ-021 SHALL, for den == 0, skip CALC and register result_valid=1, percent=255, div0=1 at E1.
REQ-022 SHALL set rr_ptr = (g+1) mod N_CH on the result_valid edge.
REQ-023 SHALL accept the next grant on the edge after result_valid at the earliest.
REQ-024 SHALL treat a req still high after its ack as a new request, arbitrated normally.
REQ-025 SHALL let enable=0 during CALC complete the in-flight computation and hold further grants.
REQ-026 SHALL ignore req bits of value X and req arriving during CALC; they are serviced only after return to IDLE.

Reset
REQ-027 SHALL, on reset, return the FSM to IDLE, clear rr_ptr, ack, busy, result_valid, percent, result_ch and div0 to 0, and clear the datapath registers.
REQ-028 SHALL, on reset asserted mid-CALC, abort the computation with no result_valid and no further ack.
REQ-029 SHALL give reset priority over every other input on the same edge.

Structure
REQ-030 SHALL place N_CH default, the widths (16, 23, 8), ITER=23, SAT=255 and the FSM state encoding in shared package perc_sched_pkg.
REQ-031 SHALL implement the iterative divider as sub-module perc_div (start, dividend, divisor -> done, quotient) instantiated once.

Verification
REQ-032 SHALL test a single request: ch1 num=1, den=3 -> ack[1] cycle after E0, result_valid at E24, percent=33, result_ch=1, div0=0.
REQ-033 SHALL test rounding and saturation: num=2, den=3 -> 67; num=50, den=100 -> 50; num=300, den=100 -> 255; num=65535, den=1 -> 255.
REQ-034 SHALL test division by zero: ch2 num=7, den=0 -> result_valid at E1, percent=255, div0=1, ack[2] single pulse.
REQ-035 SHALL test fairness: all 4 req held continuously from reset -> grant order 0,1,2,3,0, one result_valid per grant, none missed.
REQ-036 SHALL test reset mid-CALC: assert reset at E10 of a ch3 job -> no result_valid; rr_ptr=0; next simultaneous req0 and req3 grants ch0.
REQ-037 SHALL test enable low: enable=0 with req0 high -> no ack; enable=1 -> ack[0] the next cycle after the sampling edge.
